// File: rtl/ca_pkg.sv
// Shared codes for the on-the-fly carry-assimilation datapath tail.
// Holds the signed-digit encodings and the output mode selector.
package ca_pkg;

    localparam logic [1:0] D_ZERO = 2'b00;
    localparam logic [1:0] D_POS  = 2'b01;
    localparam logic [1:0] D_NEG  = 2'b10;

    typedef enum logic [1:0] {
        M_ZERO = 2'b00,
        M_PASS = 2'b01,
        M_INV  = 2'b10,
        M_NEG  = 2'b11
    } mode_e;

endpackage

// File: rtl/ca_reg_otf_core.sv
// Q/QM register pair for MSB-first signed-digit to two's complement conversion.
// clr restores the empty-conversion state; when clr and en coincide the digit lands on the cleared pair.
module otf_core
    import ca_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             en,
    input  logic [1:0]       digit,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] qm_q, qm_d;
    logic [WIDTH-1:0] q_base, qm_base;

    always_comb begin
        q_base  = clr ? '0 : q_q;
        qm_base = clr ? '1 : qm_q;
        q_d     = q_base;
        qm_d    = qm_base;
        if (en) begin
            // QM always tracks Q-1, so a -1 digit borrows from QM instead of rippling.
            case (digit)
                D_POS: begin
                    q_d  = (q_base << 1) | WIDTH'(1);
                    qm_d = q_base << 1;
                end
                D_NEG: begin
                    q_d  = (qm_base << 1) | WIDTH'(1);
                    qm_d = qm_base << 1;
                end
                default: begin
                    q_d  = q_base << 1;
                    qm_d = (qm_base << 1) | WIDTH'(1);
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q_q  <= '0;
            qm_q <= '1;
        end else begin
            q_q  <= q_d;
            qm_q <= qm_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/ca_reg_otf.sv
// On-the-fly signed-digit converter with digit counter, done/overflow flags,
// shift, output mode stage and an optional output register.
module ca_reg_otf
    import ca_pkg::*;
#(
    parameter int WIDTH   = 16,
    parameter int NDIGITS = 16,
    parameter int SHIFT   = 3,
    parameter int PIPE    = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             valid,
    input  logic [1:0]       in,
    input  logic [1:0]       mode,
    output logic [WIDTH-1:0] out,
    output logic             done,
    output logic             ovf
);

    localparam int CW = $clog2(NDIGITS + 1);
    localparam logic [CW-1:0] N_END = CW'(NDIGITS);

    // Handshake: valid-only, no backpressure. A digit is consumed on any edge with
    // valid high unless the count is full; a full count drops it and flags ovf.
    logic [CW-1:0]    cnt_q, cnt_d, cnt_base;
    logic             done_q, done_d;
    logic             ovf_q, ovf_d;
    logic             full, accept;
    logic [WIDTH-1:0] q, s, mode_out;

    always_comb begin
        full     = (cnt_q == N_END);
        accept   = valid && (start || !full);
        cnt_base = start ? '0 : cnt_q;
        cnt_d    = accept ? cnt_base + CW'(1) : cnt_base;
        done_d   = (cnt_d == N_END);
        ovf_d    = start ? 1'b0 : (ovf_q || (valid && full));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q  <= '0;
            done_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            done_q <= done_d;
            ovf_q  <= ovf_d;
        end
    end

    otf_core #(.WIDTH(WIDTH)) u_core (
        .clk   (clk),
        .reset (reset),
        .clr   (start),
        .en    (accept),
        .digit (in),
        .q     (q)
    );

    always_comb begin
        s        = q >> SHIFT;
        mode_out = '0;
        case (mode_e'(mode))
            M_ZERO: mode_out = '0;
            M_PASS: mode_out = s;
            M_INV:  mode_out = ~s;
            M_NEG:  mode_out = ~s + WIDTH'(1);
            default: mode_out = '0;
        endcase
    end

    assign ovf = ovf_q;

    generate
        if (PIPE != 0) begin : g_pipe
            logic [WIDTH-1:0] out_q, out_d;
            logic             done_p_q, done_p_d;

            // done is delayed alongside out so it marks the cycle the final value appears.
            always_comb begin
                out_d    = mode_out;
                done_p_d = done_q;
            end

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    out_q    <= '0;
                    done_p_q <= 1'b0;
                end else begin
                    out_q    <= out_d;
                    done_p_q <= done_p_d;
                end
            end

            assign out  = out_q;
            assign done = done_p_q;
        end else begin : g_direct
            assign out  = mode_out;
            assign done = done_q;
        end
    endgenerate

endmodule

// File: tb/tb_ca_reg_otf.sv
// Directed bench for ca_reg_otf: default 16-bit build plus a small 8-bit pair
// (PIPE=0 vs PIPE=1) to compare output latency.
module tb_ca_reg_otf;

    logic        clk = 1'b0;
    logic        rst;
    logic        start, valid;
    logic [1:0]  din, mode;
    logic [15:0] out;
    logic        done, ovf;

    logic        s_start, s_valid;
    logic [1:0]  s_in, s_mode;
    logic [7:0]  out_f, out_p;
    logic        done_f, done_p, ovf_f, ovf_p;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    ca_reg_otf dut (
        .clk(clk), .reset(rst), .start(start), .valid(valid), .in(din),
        .mode(mode), .out(out), .done(done), .ovf(ovf)
    );

    ca_reg_otf #(.WIDTH(8), .NDIGITS(4), .SHIFT(0), .PIPE(0)) dut_f (
        .clk(clk), .reset(rst), .start(s_start), .valid(s_valid), .in(s_in),
        .mode(s_mode), .out(out_f), .done(done_f), .ovf(ovf_f)
    );

    ca_reg_otf #(.WIDTH(8), .NDIGITS(4), .SHIFT(0), .PIPE(1)) dut_p (
        .clk(clk), .reset(rst), .start(s_start), .valid(s_valid), .in(s_in),
        .mode(s_mode), .out(out_p), .done(done_p), .ovf(ovf_p)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One edge of the default DUT; inputs return to idle afterwards.
    task automatic send(input logic st, input logic v, input logic [1:0] d);
        start = st;
        valid = v;
        din   = d;
        @(posedge clk);
        #1;
        start = 1'b0;
        valid = 1'b0;
        din   = 2'b00;
    endtask

    task automatic send_s(input logic st, input logic v, input logic [1:0] d);
        s_start = st;
        s_valid = v;
        s_in    = d;
        @(posedge clk);
        #1;
        s_start = 1'b0;
        s_valid = 1'b0;
        s_in    = 2'b00;
    endtask

    task automatic send_n(input int n, input logic [1:0] d);
        for (int i = 0; i < n; i++) send(1'b0, 1'b1, d);
    endtask

    // Non-redundant digits (+1 for a one bit, 0 for a zero bit), MSB first.
    task automatic send_word(input logic [15:0] w);
        for (int i = 15; i >= 0; i--) send(1'b0, 1'b1, w[i] ? 2'b01 : 2'b00);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; valid = 1'b0; din = 2'b00; mode = 2'b01;
        s_start = 1'b0; s_valid = 1'b0; s_in = 2'b00; s_mode = 2'b01;

        // 1. reset state
        #12;
        check_eq("rst_out_pass", out, 32'h0000);
        check_eq("rst_done", done, 1'b0);
        check_eq("rst_ovf", ovf, 1'b0);
        check_eq("rst_pipe_out", out_p, 8'h00);
        mode = 2'b10;
        #1;
        check_eq("rst_out_inv", out, 32'hFFFF);
        @(negedge clk);
        rst = 1'b0;
        #1;

        // 2. 12x0, +1, 0, 0, 0 -> Q=0x0008
        mode = 2'b01;
        send(1'b1, 1'b0, 2'b00);
        send_n(12, 2'b00);
        send_n(1, 2'b01);
        send_n(2, 2'b00);
        check_eq("t2_done_15", done, 1'b0);
        send_n(1, 2'b00);
        check_eq("t2_done_16", done, 1'b1);
        check_eq("t2_out_pass", out, 32'h0001);
        mode = 2'b10; #1;
        check_eq("t2_out_inv", out, 32'hFFFE);
        mode = 2'b11; #1;
        check_eq("t2_out_neg", out, 32'hFFFF);
        mode = 2'b00; #1;
        check_eq("t2_out_zero", out, 32'h0000);

        // 3. 15 zeros (encoded 11) then -1 -> Q=0xFFFF
        mode = 2'b01;
        send(1'b1, 1'b0, 2'b00);
        check_eq("t3_start_done", done, 1'b0);
        send_n(15, 2'b11);
        check_eq("t3_zeros_out", out, 32'h0000);
        send_n(1, 2'b10);
        check_eq("t3_out_pass", out, 32'h1FFF);
        check_eq("t3_done", done, 1'b1);
        mode = 2'b11; #1;
        check_eq("t3_out_neg", out, 32'hE001);
        mode = 2'b10; #1;
        check_eq("t3_out_inv", out, 32'hE000);

        // 4. overflow after done, then start+valid
        mode = 2'b01;
        check_eq("t4_ovf_before", ovf, 1'b0);
        send(1'b0, 1'b1, 2'b01);
        check_eq("t4_ovf_set", ovf, 1'b1);
        check_eq("t4_out_held", out, 32'h1FFF);
        check_eq("t4_done_held", done, 1'b1);
        send(1'b0, 1'b0, 2'b00);
        check_eq("t4_ovf_sticky", ovf, 1'b1);
        send(1'b1, 1'b1, 2'b01);
        check_eq("t4_ovf_clr", ovf, 1'b0);
        check_eq("t4_done_clr", done, 1'b0);
        check_eq("t4_out_q1", out, 32'h0000);
        // Q=1, cnt=1: 15 more zeros complete the word with Q=0x8000
        send_n(14, 2'b00);
        check_eq("t4_done_at_15", done, 1'b0);
        send_n(1, 2'b00);
        check_eq("t4_done_at_16", done, 1'b1);
        check_eq("t4_out_final", out, 32'h1000);

        // 5. reset mid-conversion, then fresh conversion
        send(1'b1, 1'b0, 2'b00);
        send_n(8, 2'b01);
        check_eq("t5_partial", out, 32'h001F);
        rst = 1'b1;
        #1;
        check_eq("t5_rst_out", out, 32'h0000);
        check_eq("t5_rst_done", done, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        send_word(16'hA5C3);
        check_eq("t5_fresh_out", out, 32'h14B8);
        check_eq("t5_fresh_done", done, 1'b1);
        check_eq("t5_fresh_ovf", ovf, 1'b0);

        // 6. PIPE latency: +1, -1, +1, -1 = 5 on the 8-bit pair
        send_s(1'b1, 1'b0, 2'b00);
        send_s(1'b0, 1'b1, 2'b01);
        send_s(1'b0, 1'b1, 2'b10);
        check_eq("t6_fast_mid", out_f, 8'h01);
        send_s(1'b0, 1'b1, 2'b01);
        send_s(1'b0, 1'b1, 2'b10);
        check_eq("t6_fast_out", out_f, 8'h05);
        check_eq("t6_fast_done", done_f, 1'b1);
        check_eq("t6_pipe_out_early", out_p, 8'h03);
        check_eq("t6_pipe_done_early", done_p, 1'b0);
        send_s(1'b0, 1'b0, 2'b00);
        check_eq("t6_pipe_out", out_p, 8'h05);
        check_eq("t6_pipe_done", done_p, 1'b1);
        check_eq("t6_pipe_ovf", ovf_p, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
